// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the multi-channel UART message serializer.
//   state_e           : frame FSM states
//   DEFAULT_SYNC_BYTE : default first byte of every frame
//   frame_len()       : total bytes in one frame for given header/message sizes
package uart_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    CHAN = 3'd2,
    HDR  = 3'd3,
    MSG  = 3'd4,
    CSUM = 3'd5
  } state_e;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // SYNC + channel id + header bytes + message bytes + optional checksum.
  function automatic int unsigned frame_len(input int unsigned h, input int unsigned m,
                                            input bit cs);
    return 32'd2 + (h / 32'd8) + (m / 32'd8) + (cs ? 32'd1 : 32'd0);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
//   clk_i, rst_i : clock, async active-high reset
//   req_i        : request vector
//   advance_i    : grant was taken; pointer moves to grant+1 (mod N)
//   grant_o      : combinational one-hot grant (0 when no request)
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  input  logic         advance_i,
  output logic [N-1:0] grant_o
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] gidx_s;
  logic          found_s;

  // First requester at or above the pointer wins; otherwise the lowest one (wrap).
  always_comb begin
    grant_o = '0;
    gidx_s  = '0;
    found_s = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (!found_s && (i >= int'(ptr_q)) && req_i[i]) begin
        grant_o[i] = 1'b1;
        gidx_s     = PW'(i);
        found_s    = 1'b1;
      end
    end
    for (int i = 0; i < int'(N); i++) begin
      if (!found_s && req_i[i]) begin
        grant_o[i] = 1'b1;
        gidx_s     = PW'(i);
        found_s    = 1'b1;
      end
    end
  end

  // Pointer advances past the granted channel only when the grant is consumed.
  always_comb begin
    if (advance_i) begin
      ptr_d = (gidx_s == PW'(N - 1)) ? '0 : gidx_s + PW'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/uart_msg_serializer.sv
// Arbitrates NUM_CH header+message producers and serialises the granted one
// into a byte frame: SYNC, channel id, header, message, optional XOR checksum.
//   clk_in, rst_in   : clock, async active-high reset
//   ctrl_valid_in    : per-channel "full message available"
//   header_in        : channel i at [i*HEADER_SIZE +: HEADER_SIZE]
//   message_in       : channel i at [i*MESSAGE_SIZE +: MESSAGE_SIZE]
//   bdge_ready_out   : one-hot grant, only in IDLE
//   ll_ready_in      : byte sink ready
//   ll_byte_out      : byte to send, ll_valid_out qualifies it
//   busy_out         : frame in progress
//   frame_done_out   : pulse on the final byte handshake
module uart_msg_serializer
  import uart_bridge_pkg::*;
#(
  parameter int unsigned MESSAGE_SIZE = 512,
  parameter int unsigned HEADER_SIZE  = 32,
  parameter int unsigned NUM_CH       = 2,
  parameter bit          MSB_FIRST    = 1'b1,
  parameter bit          CHECKSUM_EN  = 1'b1,
  parameter logic [7:0]  SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic [NUM_CH-1:0]              ctrl_valid_in,
  input  logic [NUM_CH*HEADER_SIZE-1:0]  header_in,
  input  logic [NUM_CH*MESSAGE_SIZE-1:0] message_in,
  output logic [NUM_CH-1:0]              bdge_ready_out,
  input  logic                           ll_ready_in,
  output logic [7:0]                     ll_byte_out,
  output logic                           ll_valid_out,
  output logic                           busy_out,
  output logic                           frame_done_out
);

  localparam int unsigned CW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned HB   = HEADER_SIZE / 8;
  localparam int unsigned MB   = MESSAGE_SIZE / 8;
  localparam int unsigned MAXB = (HB > MB) ? HB : MB;
  localparam int unsigned NW   = $clog2(MAXB + 1);

  if ((MESSAGE_SIZE % 8 != 0) || (HEADER_SIZE % 8 != 0)) begin : g_size_check
    $error("uart_msg_serializer: HEADER_SIZE and MESSAGE_SIZE must be multiples of 8");
  end

  state_e                  state_q, state_d;
  logic [HEADER_SIZE-1:0]  hdr_q, hdr_d, hdr_sel_s;
  logic [MESSAGE_SIZE-1:0] msg_q, msg_d, msg_sel_s;
  logic [CW-1:0]           chan_q, chan_d, chan_sel_s;
  logic [NW-1:0]           cnt_q, cnt_d;
  logic [7:0]              csum_q, csum_d;
  logic [NUM_CH-1:0]       grant_s;
  logic                    accept_s, hs_s, last_s;
  logic [7:0]              hdr_byte_s, msg_byte_s;

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk_i     (clk_in),
    .rst_i     (rst_in),
    .req_i     (ctrl_valid_in),
    .advance_i (accept_s),
    .grant_o   (grant_s)
  );

  assign accept_s   = (state_q == IDLE) && (|grant_s);
  assign hs_s       = (state_q != IDLE) && ll_ready_in;
  // Counter holds bytes still to send in the current section.
  assign last_s     = (cnt_q == NW'(1));
  assign hdr_byte_s = MSB_FIRST ? hdr_q[HEADER_SIZE-1 -: 8]  : hdr_q[7:0];
  assign msg_byte_s = MSB_FIRST ? msg_q[MESSAGE_SIZE-1 -: 8] : msg_q[7:0];

  // Select the granted channel's header, message and id (grant is one-hot).
  always_comb begin
    hdr_sel_s  = '0;
    msg_sel_s  = '0;
    chan_sel_s = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (grant_s[i]) begin
        hdr_sel_s  = header_in[i*HEADER_SIZE +: HEADER_SIZE];
        msg_sel_s  = message_in[i*MESSAGE_SIZE +: MESSAGE_SIZE];
        chan_sel_s = CW'(i);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept_s ? SYNC : IDLE;
      SYNC:    state_d = hs_s ? CHAN : SYNC;
      CHAN:    state_d = hs_s ? HDR : CHAN;
      HDR:     state_d = (hs_s && last_s) ? MSG : HDR;
      MSG: begin
        if (hs_s && last_s) state_d = CHECKSUM_EN ? CSUM : IDLE;
        else                state_d = MSG;
      end
      CSUM:    state_d = hs_s ? IDLE : CSUM;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; the byte is a pure function of registered state.
  always_comb begin
    bdge_ready_out = (state_q == IDLE) ? grant_s : '0;
    ll_valid_out   = (state_q != IDLE);
    busy_out       = (state_q != IDLE);
    frame_done_out = hs_s && ((state_q == CSUM) ||
                              ((state_q == MSG) && last_s && !CHECKSUM_EN));
    case (state_q)
      SYNC:    ll_byte_out = SYNC_BYTE;
      CHAN:    ll_byte_out = 8'(chan_q);
      HDR:     ll_byte_out = hdr_byte_s;
      MSG:     ll_byte_out = msg_byte_s;
      CSUM:    ll_byte_out = csum_q;
      default: ll_byte_out = 8'h00;
    endcase
  end

  // Datapath next state: load on accept, shift/count/accumulate on each handshake.
  always_comb begin
    hdr_d  = hdr_q;
    msg_d  = msg_q;
    chan_d = chan_q;
    cnt_d  = cnt_q;
    csum_d = csum_q;
    if (accept_s) begin
      hdr_d  = hdr_sel_s;
      msg_d  = msg_sel_s;
      chan_d = chan_sel_s;
      cnt_d  = '0;
      csum_d = 8'h00;
    end else if (hs_s) begin
      case (state_q)
        CHAN: begin
          csum_d = csum_q ^ 8'(chan_q);
          cnt_d  = NW'(HB);
        end
        HDR: begin
          csum_d = csum_q ^ hdr_byte_s;
          hdr_d  = MSB_FIRST ? (hdr_q << 4'd8) : (hdr_q >> 4'd8);
          cnt_d  = last_s ? NW'(MB) : (cnt_q - NW'(1));
        end
        MSG: begin
          csum_d = csum_q ^ msg_byte_s;
          msg_d  = MSB_FIRST ? (msg_q << 4'd8) : (msg_q >> 4'd8);
          cnt_d  = last_s ? '0 : (cnt_q - NW'(1));
        end
        default: cnt_d = cnt_q;
      endcase
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hdr_q  <= '0;
      msg_q  <= '0;
      chan_q <= '0;
      cnt_q  <= '0;
      csum_q <= 8'h00;
    end else begin
      hdr_q  <= hdr_d;
      msg_q  <= msg_d;
      chan_q <= chan_d;
      cnt_q  <= cnt_d;
      csum_q <= csum_d;
    end
  end

endmodule
